// File: rtl/rtc_reg_bank_pkg.sv
// Shared types and defaults for the RTC register bank: capture FSM states,
// default geometry and an index-width helper.
package rtc_reg_bank_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } cap_state_e;

  localparam int DEF_NUM_REGS = 11;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_DWELL    = 22;
  localparam int DWELL_W      = 8;

  // Index width for n entries; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rtc_reg_bank_if.sv
// Bus bundle between the RTC bus front end and the register bank: capture,
// rotating scan and random-access read channels.
interface rtc_reg_bank_if
  import rtc_reg_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = clog2_min1(DEF_NUM_REGS)
);

  logic              burst_start;
  logic              cap_valid;
  logic [DATA_W-1:0] data_in;
  logic [IDX_W-1:0]  cap_idx;
  logic              burst_done;
  logic              overflow;
  logic              scan_en;
  logic [IDX_W-1:0]  scan_idx;
  logic [DATA_W-1:0] scan_data;
  logic              scan_valid;
  logic [IDX_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output burst_start, cap_valid, data_in, scan_en, rd_addr,
    input  cap_idx, burst_done, overflow, scan_idx, scan_data, scan_valid, rd_data
  );

  modport slave (
    input  burst_start, cap_valid, data_in, scan_en, rd_addr,
    output cap_idx, burst_done, overflow, scan_idx, scan_data, scan_valid, rd_data
  );

endinterface

// File: rtl/rtc_scan_timer.sv
// Dwell counter and scan index rotation: each index is held for DWELL
// cycles while scan_en is high; everything returns to zero when it drops.
module rtc_scan_timer
  import rtc_reg_bank_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DWELL    = DEF_DWELL,
  parameter int IDX_W    = clog2_min1(DEF_NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scan_en,
  output logic [IDX_W-1:0] scan_idx
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REGS - 1);

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // Next dwell count and index
  always_comb begin
    dwell_d = dwell_q;
    idx_d   = idx_q;
    if (!scan_en) begin
      dwell_d = '0;
      idx_d   = '0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d = '0;
      idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
      idx_d   = idx_q;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_q <= '0;
      idx_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
    end
  end

  assign scan_idx = idx_q;

endmodule

// File: rtl/rtc_reg_bank.sv
// Captures a burst of RTC bytes into a register bank and presents them on a
// rotating scan port and a random-access read port.
// Define RTC_REG_BANK_SNAPSHOT_EN to stage bursts in a shadow bank that only
// becomes visible when the burst completes.
module rtc_reg_bank
  import rtc_reg_bank_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DWELL    = DEF_DWELL
) (
  input  logic          clk,
  input  logic          reset,
  rtc_reg_bank_if.slave bus
);

  localparam int IDX_W = clog2_min1(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef logic [DATA_W-1:0] word_t;

  cap_state_e       state_q, state_d;
  logic [IDX_W-1:0] cap_idx_q, cap_idx_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  word_t            bank_q [NUM_REGS];
  word_t            bank_d [NUM_REGS];
  word_t            scan_data_q, scan_data_d;
  logic             scan_valid_q, scan_valid_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  word_t            rd_data_q, rd_data_d;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [IDX_W-1:0] timer_idx_s;

`ifdef RTC_REG_BANK_SNAPSHOT_EN
  word_t shadow_q [NUM_REGS];
  word_t shadow_d [NUM_REGS];
`endif

  rtc_scan_timer #(
    .NUM_REGS (NUM_REGS),
    .DWELL    (DWELL),
    .IDX_W    (IDX_W)
  ) u_scan_timer (
    .clk      (clk),
    .reset    (reset),
    .scan_en  (bus.scan_en),
    .scan_idx (timer_idx_s)
  );

  // Capture FSM: a burst_start always wins and restarts indexing at zero
  always_comb begin
    state_d   = state_q;
    cap_idx_d = cap_idx_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = cap_idx_q;
    if (bus.burst_start) begin
      state_d = ST_CAPTURE;
      ovf_d   = 1'b0;
      if (bus.cap_valid) begin
        wr_en_s   = 1'b1;
        wr_idx_s  = '0;
        cap_idx_d = IDX_W'(1);
      end else begin
        cap_idx_d = '0;
      end
    end else begin
      case (state_q)
        ST_CAPTURE: begin
          if (bus.cap_valid) begin
            wr_en_s = 1'b1;
            if (cap_idx_q == LAST_IDX) begin
              state_d   = ST_IDLE;
              cap_idx_d = '0;
              done_d    = 1'b1;
            end else begin
              cap_idx_d = cap_idx_q + IDX_W'(1);
            end
          end else begin
            cap_idx_d = cap_idx_q;
          end
        end
        ST_IDLE: begin
          if (bus.cap_valid) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          cap_idx_d = '0;
        end
      endcase
    end
  end

  // Bank update: direct writes, or shadow staging with whole-bank publish on completion
  always_comb begin
    bank_d = bank_q;
`ifdef RTC_REG_BANK_SNAPSHOT_EN
    shadow_d = shadow_q;
    if (wr_en_s) begin
      shadow_d[wr_idx_s] = bus.data_in;
    end else begin
      shadow_d = shadow_q;
    end
    if (done_d) begin
      bank_d = shadow_d;
    end else begin
      bank_d = bank_q;
    end
`else
    if (wr_en_s) begin
      bank_d[wr_idx_s] = bus.data_in;
    end else begin
      bank_d = bank_q;
    end
`endif
  end

  // Output staging: scan index is delayed so it names the entry on scan_data
  always_comb begin
    scan_valid_d = bus.scan_en;
    if (bus.scan_en) begin
      scan_data_d = bank_q[timer_idx_s];
      scan_idx_d  = timer_idx_s;
    end else begin
      scan_data_d = '0;
      scan_idx_d  = '0;
    end
    if (int'(bus.rd_addr) < NUM_REGS) begin
      rd_data_d = bank_q[bus.rd_addr];
    end else begin
      rd_data_d = '0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cap_idx_q    <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_idx_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cap_idx_q    <= cap_idx_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      scan_data_q  <= scan_data_d;
      scan_valid_q <= scan_valid_d;
      scan_idx_q   <= scan_idx_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Register bank storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      bank_q <= bank_d;
    end
  end

`ifdef RTC_REG_BANK_SNAPSHOT_EN
  // Shadow storage for the burst in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign bus.cap_idx    = cap_idx_q;
  assign bus.burst_done = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.scan_idx   = scan_idx_q;
  assign bus.scan_data  = scan_data_q;
  assign bus.scan_valid = scan_valid_q;
  assign bus.rd_data    = rd_data_q;

endmodule

// File: tb/tb_rtc_reg_bank.sv
// Scoreboard bench for rtc_reg_bank: a default instance and a NUM_REGS=4,
// DWELL=1 instance, directed stimulus with hand-computed expectations.
module tb_rtc_reg_bank;
  import rtc_reg_bank_pkg::*;

  localparam int NA  = 11;
  localparam int DA  = 22;
  localparam int NB  = 4;
  localparam int DB  = 1;
  localparam int IWA = clog2_min1(NA);
  localparam int IWB = clog2_min1(NB);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rtc_reg_bank_if #(.DATA_W(8), .IDX_W(IWA)) bus_a ();
  rtc_reg_bank_if #(.DATA_W(8), .IDX_W(IWB)) bus_b ();

  rtc_reg_bank #(.NUM_REGS(NA), .DATA_W(8), .DWELL(DA)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  rtc_reg_bank #(.NUM_REGS(NB), .DATA_W(8), .DWELL(DB)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {string name; int sel; int due; logic [31:0] exp;} probe_t;
  typedef struct {logic [31:0] idx; logic [31:0] data;} scan_t;

  probe_t probe_q[$];
  scan_t  scan_q[$];
  int     done_q[$];
  int     cyc = 0;
  bit     sel_b = 1'b0;
  int     n_checks = 0;
  int     n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // 0 cap_idx, 1 burst_done, 2 overflow, 3 scan_idx, 4 scan_data, 5 scan_valid, 6 rd_data
  function automatic logic [31:0] obs(input int sel);
    logic [31:0] a, b;
    case (sel)
      0: begin a = 32'(bus_a.cap_idx);    b = 32'(bus_b.cap_idx);    end
      1: begin a = 32'(bus_a.burst_done); b = 32'(bus_b.burst_done); end
      2: begin a = 32'(bus_a.overflow);   b = 32'(bus_b.overflow);   end
      3: begin a = 32'(bus_a.scan_idx);   b = 32'(bus_b.scan_idx);   end
      4: begin a = 32'(bus_a.scan_data);  b = 32'(bus_b.scan_data);  end
      5: begin a = 32'(bus_a.scan_valid); b = 32'(bus_b.scan_valid); end
      6: begin a = 32'(bus_a.rd_data);    b = 32'(bus_b.rd_data);    end
      default: begin a = 32'hDEAD_BEEF; b = 32'hDEAD_BEEF; end
    endcase
    return sel_b ? b : a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, dut %s)",
                  name, act, exp, cyc, sel_b ? "b" : "a");
  endtask

  // Monitor: pops expectations as the DUT presents outputs
  initial begin
    forever begin
      @(negedge clk);
      if (obs(1) == 32'd1) begin
        if (done_q.size() == 0) chk("burst_done_spurious", obs(1), 32'd0);
        else chk("burst_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
      end
      if (obs(5) == 32'd1) begin
        if (scan_q.size() == 0) chk("scan_valid_spurious", obs(5), 32'd0);
        else begin
          scan_t e;
          e = scan_q.pop_front();
          chk("scan_idx", obs(3), e.idx);
          chk("scan_data", obs(4), e.data);
        end
      end
      for (int i = 0; i < probe_q.size(); ) begin
        if (probe_q[i].due == cyc) begin
          chk(probe_q[i].name, obs(probe_q[i].sel), probe_q[i].exp);
          probe_q.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string name, input int sel, input logic [31:0] exp, input int lat);
    probe_q.push_back('{name, sel, cyc + lat, exp});
  endtask

  task automatic drive(input logic bs, input logic cv, input logic [7:0] d);
    if (sel_b) begin
      bus_b.burst_start = bs; bus_b.cap_valid = cv; bus_b.data_in = d;
    end else begin
      bus_a.burst_start = bs; bus_a.cap_valid = cv; bus_a.data_in = d;
    end
  endtask

  task automatic set_rd(input int addr);
    if (sel_b) bus_b.rd_addr = IWB'(addr);
    else bus_a.rd_addr = IWA'(addr);
  endtask

  task automatic set_scan(input logic en);
    if (sel_b) bus_b.scan_en = en;
    else bus_a.scan_en = en;
  endtask

  task automatic rd_chk(input string name, input int addr, input logic [31:0] exp);
    set_rd(addr);
    probe(name, 6, exp, 1);
    tick();
  endtask

  // Full burst of 0x11, 0x22, ... ; also reads index 3 in the cycle it is written
  task automatic full_burst(input int n);
    drive(1'b1, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, 8'(17 * (i + 1)));
      probe("cap_idx_in_burst", 0, 32'(i), 0);
      if (i == 3) begin
        set_rd(3);
        probe("rd_same_cycle_old", 6, 32'h0, 1);
      end
      if (i == n - 1) done_q.push_back(cyc + 1);
      tick();
    end
    drive(1'b0, 1'b0, 8'h00);
    probe("cap_idx_after_burst", 0, 32'h0, 0);
    probe("burst_done_one_cycle", 1, 32'h0, 1);
    tick();
  endtask

  task automatic scan_run(input int n, input int dwell, input int extra);
    int len;
    len = n * dwell + extra;
    for (int k = 0; k < len; k++) begin
      scan_t e;
      e.idx  = 32'((k / dwell) % n);
      e.data = 32'(17 * (((k / dwell) % n) + 1));
      scan_q.push_back(e);
    end
    set_scan(1'b1);
    repeat (len) tick();
    set_scan(1'b0);
    probe("scan_valid_off", 5, 32'h0, 1);
    probe("scan_idx_off", 3, 32'h0, 1);
    probe("scan_data_off", 4, 32'h0, 1);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    bus_a.burst_start = 1'b0; bus_a.cap_valid = 1'b0; bus_a.data_in = 8'h00;
    bus_a.scan_en = 1'b0;     bus_a.rd_addr = '0;
    bus_b.burst_start = 1'b0; bus_b.cap_valid = 1'b0; bus_b.data_in = 8'h00;
    bus_b.scan_en = 1'b0;     bus_b.rd_addr = '0;
    tick();
    tick();
    for (int s = 0; s <= 6; s++) probe($sformatf("reset_sel%0d", s), s, 32'h0, 0);
    tick();
    reset = 1'b1;
    tick();

    // Default instance: full burst, reads, scan
    full_burst(NA);
    rd_chk("rd_addr3", 3, 32'h44);
    rd_chk("rd_addr0", 0, 32'h11);
    rd_chk("rd_addr10", 10, 32'hBB);
    rd_chk("rd_addr11_oob", 11, 32'h0);
    rd_chk("rd_addr15_oob", 15, 32'h0);
    scan_run(NA, DA, 3);

    // Overflow outside a burst
    drive(1'b0, 1'b1, 8'hFF);
    tick();
    probe("overflow_set", 2, 32'h1, 0);
    drive(1'b0, 1'b0, 8'h00);
    tick();
    probe("overflow_sticky", 2, 32'h1, 0);
    rd_chk("bank0_after_ovf", 0, 32'h11);
    rd_chk("bank10_after_ovf", 10, 32'hBB);
    drive(1'b1, 1'b0, 8'h00);
    tick();
    probe("overflow_clear", 2, 32'h0, 0);
    probe("cap_idx_on_start", 0, 32'h0, 0);

    // Start+write same cycle, partial burst, then abort
    drive(1'b1, 1'b1, 8'h55);
    tick();
    probe("start_write_idx", 0, 32'h1, 0);
    for (int j = 1; j < 5; j++) begin
      drive(1'b0, 1'b1, 8'h55);
      tick();
    end
    drive(1'b1, 1'b0, 8'h00);
    tick();
    probe("abort_idx", 0, 32'h0, 0);
    probe("abort_no_done", 1, 32'h0, 0);
    drive(1'b0, 1'b0, 8'h00);
`ifdef RTC_REG_BANK_SNAPSHOT_EN
    rd_chk("abort_bank0", 0, 32'h11);
    rd_chk("abort_bank1", 1, 32'h22);
`else
    rd_chk("abort_bank0", 0, 32'h55);
    rd_chk("abort_bank1", 1, 32'h55);
`endif
    rd_chk("abort_bank4", 4, 32'h55);
    rd_chk("abort_bank5", 5, 32'h66);

    // Reset asserted during the 6th write of a new burst
    set_rd(1);
    for (int j = 0; j < 5; j++) begin
      drive(1'b0, 1'b1, 8'h77);
      tick();
    end
    drive(1'b0, 1'b1, 8'h77);
    #2;
    reset = 1'b0;
    probe("async_rst_cap_idx", 0, 32'h0, 0);
    probe("async_rst_rd_data", 6, 32'h0, 0);
    probe("async_rst_overflow", 2, 32'h0, 0);
    probe("async_rst_scan_valid", 5, 32'h0, 0);
    tick();
    drive(1'b0, 1'b0, 8'h00);
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b1, 8'h99);
    tick();
    probe("post_rst_start_idx", 0, 32'h1, 0);
    drive(1'b0, 1'b0, 8'h00);
    rd_chk("post_rst_bank1", 1, 32'h0);
`ifdef RTC_REG_BANK_SNAPSHOT_EN
    rd_chk("post_rst_bank0", 0, 32'h0);
`else
    rd_chk("post_rst_bank0", 0, 32'h99);
`endif
    rd_chk("post_rst_bank5", 5, 32'h0);

    // Small instance: NUM_REGS=4, DWELL=1
    set_rd(0);
    sel_b = 1'b1;
    tick();
    full_burst(NB);
    rd_chk("b_rd_addr3", 3, 32'h44);
    rd_chk("b_rd_addr2", 2, 32'h33);
    rd_chk("b_rd_addr0", 0, 32'h11);
    scan_run(NB, DB, 5);

    repeat (3) tick();
    chk("scan_q_drained", 32'(scan_q.size()), 32'h0);
    chk("done_q_drained", 32'(done_q.size()), 32'h0);
    chk("probe_q_drained", 32'(probe_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
